// File: rtl/coin_pkg.sv
// Shared types and default constants for the coin collector.
// Holds the scan FSM encoding and default hitbox geometry.
package coin_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CHECK = 3'd2,
    S_ERASE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam int DEF_N_COINS = 10;
  localparam int DEF_XW      = 8;
  localparam int DEF_YW      = 7;
  localparam int DEF_PW      = 4;
  localparam int DEF_PH      = 4;
  localparam int DEF_SCORE_W = 8;

endpackage

// File: rtl/coin_table.sv
// Coin slot table: one write port, one registered read port,
// and a per-entry valid clear.
module coin_table #(
  parameter int N  = 10,
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [XW-1:0] wr_x_i,
  input  logic [YW-1:0] wr_y_i,
  input  logic          clr_en_i,
  input  logic [IW-1:0] clr_idx_i,
  input  logic          rd_en_i,
  input  logic [IW-1:0] rd_idx_i,
  output logic          rd_valid_o,
  output logic [XW-1:0] rd_x_o,
  output logic [YW-1:0] rd_y_o,
  output logic [N-1:0]  valid_o
);

  logic [N-1:0]  valid_q;
  logic [XW-1:0] x_q [N];
  logic [YW-1:0] y_q [N];
  logic          rd_valid_q;
  logic [XW-1:0] rd_x_q;
  logic [YW-1:0] rd_y_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= '0;
    end else begin
      if (wr_en_i)  valid_q[wr_idx_i]  <= 1'b1;
      if (clr_en_i) valid_q[clr_idx_i] <= 1'b0;
    end
  end

  // Coordinates need no reset: valid gates their use.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      x_q[wr_idx_i] <= wr_x_i;
      y_q[wr_idx_i] <= wr_y_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_valid_q <= 1'b0;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
    end else if (rd_en_i) begin
      rd_valid_q <= valid_q[rd_idx_i];
      rd_x_q     <= x_q[rd_idx_i];
      rd_y_q     <= y_q[rd_idx_i];
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_x_o     = rd_x_q;
  assign rd_y_o     = rd_y_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/coin_collector.sv
// Coin collector: scans every slot against the latched player
// hitbox, erasing and scoring each coin it touches.
module coin_collector
  import coin_pkg::*;
#(
  parameter int N_COINS = DEF_N_COINS,
  parameter int XW      = DEF_XW,
  parameter int YW      = DEF_YW,
  parameter int PW      = DEF_PW,
  parameter int PH      = DEF_PH,
  parameter int SCORE_W = DEF_SCORE_W,
  localparam int IW     = $clog2(N_COINS)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [XW-1:0]      player_x,
  input  logic [YW-1:0]      player_y,
  input  logic               load_en,
  input  logic [IW-1:0]      load_idx,
  input  logic [XW-1:0]      load_x,
  input  logic [YW-1:0]      load_y,
  output logic               busy,
  output logic               done,
  output logic               hit,
  output logic [IW-1:0]      hit_idx,
  output logic [SCORE_W-1:0] score,
  output logic               all_collected
);

  state_e state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [XW-1:0]      px_q, px_d;
  logic [YW-1:0]      py_q, py_d;
  logic [SCORE_W-1:0] score_q, score_d;

  logic          wr_en, rd_en, clr_en;
  logic          t_valid;
  logic [XW-1:0] t_x;
  logic [YW-1:0] t_y;
  logic [N_COINS-1:0] valid;
  logic          last, in_box;
  logic [XW:0]   px_end;
  logic [YW:0]   py_end;

  assign last = (idx_q == IW'(N_COINS - 1));
  assign wr_en = load_en && (state_q == S_IDLE) &&
                 ({1'b0, load_idx} < (IW + 1)'(N_COINS));

  // One extra bit keeps the far hitbox edge from wrapping.
  assign px_end = {1'b0, px_q} + (XW + 1)'(PW);
  assign py_end = {1'b0, py_q} + (YW + 1)'(PH);
  assign in_box = t_valid &&
                  (t_x >= px_q) && ({1'b0, t_x} <= px_end) &&
                  (t_y >= py_q) && ({1'b0, t_y} <= py_end);

  coin_table #(
    .N  (N_COINS),
    .XW (XW),
    .YW (YW),
    .IW (IW)
  ) u_table (
    .clk        (clk),
    .resetn     (resetn),
    .wr_en_i    (wr_en),
    .wr_idx_i   (load_idx),
    .wr_x_i     (load_x),
    .wr_y_i     (load_y),
    .clr_en_i   (clr_en),
    .clr_idx_i  (idx_q),
    .rd_en_i    (rd_en),
    .rd_idx_i   (idx_q),
    .rd_valid_o (t_valid),
    .rd_x_o     (t_x),
    .rd_y_o     (t_y),
    .valid_o    (valid)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      px_q    <= px_d;
      py_q    <= py_d;
      score_q <= score_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_READ;
      S_READ:  state_d = S_CHECK;
      S_CHECK: begin
        if (in_box)    state_d = S_ERASE;
        else if (last) state_d = S_DONE;
        else           state_d = S_READ;
      end
      S_ERASE: state_d = last ? S_DONE : S_READ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    px_d    = px_q;
    py_d    = py_q;
    score_d = score_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d = '0;
          px_d  = player_x;
          py_d  = player_y;
        end
      end
      S_CHECK: if (!in_box && !last) idx_d = idx_q + 1'b1;
      S_ERASE: begin
        if (!last) idx_d = idx_q + 1'b1;
        if (score_q != '1) score_d = score_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_DONE);
    hit    = (state_q == S_ERASE);
    rd_en  = (state_q == S_READ);
    clr_en = (state_q == S_ERASE);
  end

  assign hit_idx       = hit ? idx_q : '0;
  assign score         = score_q;
  assign all_collected = ~|valid;

endmodule

// File: tb/tb_coin_collector.sv
// Bench for coin_collector: directed vectors, corner sequences
// and randomized scans against a slot-level reference model.
module tb_coin_collector;

  localparam int N  = 10;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int IW = $clog2(N);

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic [XW-1:0] player_x = '0;
  logic [YW-1:0] player_y = '0;
  logic load_en = 1'b0;
  logic [IW-1:0] load_idx = '0;
  logic [XW-1:0] load_x = '0;
  logic [YW-1:0] load_y = '0;

  logic busy, done, hit, all_c;
  logic [IW-1:0] hit_idx;
  logic [7:0] score;
  logic busy_s, done_s, hit_s, all_s;
  logic [IW-1:0] hit_idx_s;
  logic [1:0] score_s;

  always #5 clk = ~clk;

  coin_collector u_dut (
    .clk(clk), .resetn(resetn), .start(start),
    .player_x(player_x), .player_y(player_y),
    .load_en(load_en), .load_idx(load_idx),
    .load_x(load_x), .load_y(load_y),
    .busy(busy), .done(done), .hit(hit), .hit_idx(hit_idx),
    .score(score), .all_collected(all_c)
  );

  coin_collector #(.SCORE_W(2)) u_sat (
    .clk(clk), .resetn(resetn), .start(start),
    .player_x(player_x), .player_y(player_y),
    .load_en(load_en), .load_idx(load_idx),
    .load_x(load_x), .load_y(load_y),
    .busy(busy_s), .done(done_s), .hit(hit_s),
    .hit_idx(hit_idx_s), .score(score_s),
    .all_collected(all_s)
  );

  int passed = 0;
  int total = 0;

  bit mvalid [N];
  int mx [N];
  int my [N];
  int mscore;

  typedef struct {
    int cx; int cy; int px; int py; int h;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic bit touches(int cx, int cy, int px, int py);
    return cx >= px && cx <= px + 4 && cy >= py && cy <= py + 4;
  endfunction

  function automatic int sat(int v, int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic int n_valid();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(mvalid[i]);
    return c;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    start = 1'b0;
    load_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    for (int i = 0; i < N; i++) mvalid[i] = 1'b0;
    mscore = 0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_hit_idx", int'(hit_idx), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_all", int'(all_c), 1);
  endtask

  task automatic load(input int idx, input int x, input int y);
    @(negedge clk);
    load_en = 1'b1;
    load_idx = IW'(idx);
    load_x = XW'(x);
    load_y = YW'(y);
    @(posedge clk);
    #1 load_en = 1'b0;
    if (idx < N) begin
      mvalid[idx] = 1'b1;
      mx[idx] = x;
      my[idx] = y;
    end
  endtask

  task automatic do_scan(input int px, input int py,
                         input bit noise, input string nm);
    int exp_q[$];
    int got[$];
    int cyc, dcyc, busy_low;
    bit seen;
    for (int i = 0; i < N; i++) begin
      if (mvalid[i] && touches(mx[i], my[i], px, py)) begin
        exp_q.push_back(i);
        mvalid[i] = 1'b0;
        mscore++;
      end
    end
    @(negedge clk);
    player_x = XW'(px);
    player_y = YW'(py);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    seen = 1'b0;
    dcyc = -1;
    busy_low = 0;
    while (!seen && cyc < 200) begin
      if (noise) begin
        player_x = XW'($urandom);
        player_y = YW'($urandom);
        load_en = 1'b1;
        load_idx = IW'($urandom);
        load_x = XW'($urandom);
        load_y = YW'($urandom);
        start = 1'(($urandom_range(0, 3) != 0) || cyc > 2 * N);
      end
      @(negedge clk);
      if (!busy) busy_low++;
      if (hit) got.push_back(int'(hit_idx));
      if (done) begin
        seen = 1'b1;
        dcyc = cyc;
      end
      @(posedge clk);
      #1 cyc++;
    end
    start = 1'b0;
    load_en = 1'b0;
    chk({nm, "_done_cyc"}, dcyc, 2 * N + 1 + exp_q.size());
    chk({nm, "_busy"}, busy_low, 0);
    chk({nm, "_nhits"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk({nm, "_hit_idx"}, got[i], exp_q[i]);
    @(negedge clk);
    chk({nm, "_idle"}, int'(busy), 0);
    chk({nm, "_score"}, int'(score), sat(mscore, 255));
    chk({nm, "_score_sat"}, int'(score_s), sat(mscore, 3));
    chk({nm, "_all"}, int'(all_c), int'(n_valid() == 0));
  endtask

  task automatic mid_reset();
    int dn = 0;
    load(0, 20, 20);
    @(negedge clk);
    player_x = 8'd18;
    player_y = 7'd18;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) dn++;
    end
    resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    for (int i = 0; i < N; i++) mvalid[i] = 1'b0;
    mscore = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("midrst_done", dn, 0);
    chk("midrst_score", int'(score), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_all", int'(all_c), 1);
  endtask

  initial begin
    vecs[0] = '{10, 20, 8, 18, 1};
    vecs[1] = '{12, 20, 8, 20, 1};
    vecs[2] = '{13, 20, 8, 20, 0};
    vecs[3] = '{1, 0, 254, 0, 0};
    vecs[4] = '{8, 18, 8, 18, 1};
    vecs[5] = '{7, 18, 8, 18, 0};
    vecs[6] = '{12, 22, 8, 18, 1};
    vecs[7] = '{12, 23, 8, 18, 0};
    vecs[8] = '{255, 127, 252, 124, 1};
    vecs[9] = '{0, 0, 255, 127, 0};

    do_reset();
    do_scan(0, 0, 1'b0, "empty");

    for (int v = 0; v < 10; v++) begin
      do_reset();
      load(3, vecs[v].cx, vecs[v].cy);
      do_scan(vecs[v].px, vecs[v].py, 1'b0, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d_table", v), int'(score), vecs[v].h);
    end

    do_reset();
    load(12, 9, 9);
    chk("oob_load_all", int'(all_c), 1);
    for (int i = 0; i < 5; i++) load(i, 10 + i, 10);
    load(7, 100, 100);
    do_scan(10, 8, 1'b0, "five");
    chk("five_sat_fixed", int'(score_s), 3);

    do_reset();
    load(2, 50, 50);
    do_scan(48, 48, 1'b1, "noisy");

    do_reset();
    mid_reset();

    do_reset();
    for (int it = 0; it < 8; it++) begin
      int px, py;
      px = $urandom_range(0, 255);
      py = $urandom_range(0, 127);
      for (int k = 0; k < 4; k++)
        load($urandom_range(0, 15),
             (px + $urandom_range(0, 8) - 2) & 255,
             (py + $urandom_range(0, 8) - 2) & 127);
      do_scan(px, py, 1'(it % 2), $sformatf("rnd%0d", it));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
